packet_injector: RTL
====================

PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 Parameter routerID, default 6'b000_000: ID of the attached router, reserved for logging and naming.
REQ-002 Parameter ModuleID, default 6'b000_000: this PE's ID, placed in the packet SenderID field.
REQ-003 Parameter packetwidth, default 26: packet bus width.
REQ-004 Parameter INTERVAL, 16 bits, default 10, legal range 1..65535: idle cycles between packets.
REQ-005 Parameter NUM_PACKETS, 10 bits, default 100, legal range 1..1023: packets sent per run.
REQ-006 Parameter LFSR_SEED, 9 bits, default 9'h1FF, nonzero: payload generator seed.
REQ-007 clk  input  1  single clock; all logic on posedge clk.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 Enable  input  1  high = injection allowed; low = pause.
REQ-010 DnStrFull  input  1  high = router local input buffer full.
REQ-011 GntDnStr  input  1  grant from router local input port.
REQ-012 ReqDnStr  output  1  request to router local input port.
REQ-013 PacketOut  output  packetwidth  packet presented to the router.
REQ-014 SentCount  output  10  number of packets granted so far.
REQ-015 Done  output  1  high = NUM_PACKETS granted.

Function
REQ-016 Packet format SHALL be: [25]=1 (valid marker), [24:15]=PacketID, [14:9]=ModuleID, [8:0]=payload.
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have the states IDLE, GAP, REQ, RELEASE and DONE.
REQ-019 IDLE: when Enable=1, the FSM SHALL load the gap counter with INTERVAL and go to GAP.
REQ-020 GAP: the gap counter SHALL decrement only while Enable=1, and SHALL hold while Enable=0.
REQ-021 GAP exit: when the counter equals 1, Enable=1 and DnStrFull=0, the FSM SHALL go to REQ, with ReqDnStr<=1 on the same edge.
REQ-022 GAP stall: when the counter equals 1 and DnStrFull=1, the FSM SHALL stay in GAP with the counter held at 1.
REQ-023 REQ: ReqDnStr and PacketOut SHALL stay stable until GntDnStr=1 is sampled; Enable and DnStrFull SHALL be ignored in REQ.
REQ-024 Grant: when GntDnStr=1 is sampled in REQ, on the same edge ReqDnStr<=0, SentCount+1, PacketID+1 (10-bit wrap), the LFSR advances, and the FSM goes to RELEASE.
REQ-025 RELEASE: the FSM SHALL wait until GntDnStr=0 is sampled, then go to DONE if SentCount==NUM_PACKETS, else reload the counter with INTERVAL and go to GAP.
REQ-026 RELEASE SHALL prevent a lingering grant from being counted twice.
REQ-027 DONE: Done SHALL be 1 and ReqDnStr SHALL be 0 until reset.
REQ-028 Payload SHALL be a 9-bit Fibonacci LFSR, polynomial x^9+x^5+1, that advances only on a grant.
REQ-029 PacketOut SHALL always reflect the current PacketID and LFSR value, including while idle.
REQ-030 Minimum spacing between the falling edge of ReqDnStr and the next rising edge SHALL be INTERVAL+1 cycles.
REQ-031 A grant sampled in any state other than REQ SHALL be ignored.

Reset
REQ-032 When reset=0 at a posedge, the block SHALL go to IDLE with ReqDnStr=0, Done=0, SentCount=0, PacketID=0, LFSR=LFSR_SEED, and gap counter=0.
REQ-033 After reset, PacketOut SHALL be {1'b1, 10'd0, ModuleID, LFSR_SEED}.
REQ-034 Reset during REQ SHALL drop ReqDnStr on that edge, and the in-flight packet SHALL NOT be counted.

Structure
REQ-035 A shared noc package SHALL hold: packet field offsets (VALID_BIT=25, PKTID_MSB=24/LSB=15, SENDER_MSB=14/LSB=9, DATA_MSB=8/LSB=0), the packetwidth default, and the injector state encodings.
REQ-036 The block SHALL contain one sub-module, lfsr9, with ports clk, reset, advance, seed and q[8:0].

Verification
REQ-037 Directed scenario, back-to-back with collector responder: INTERVAL=3, NUM_PACKETS=2, Enable=1 -> ReqDnStr rises 4 cycles after reset release; Gnt follows 1 cycle later; second Req rises 5 cycles after the first Req falls; Done=1 after the second grant; SentCount=2; PacketIDs 0 and 1.
REQ-038 Directed scenario, full back-pressure: DnStrFull=1 held for 20 cycles at GAP expiry -> ReqDnStr stays 0 throughout; Req rises on the first edge after DnStrFull=0.
REQ-039 Directed scenario, Enable pause: Enable=0 for 5 cycles mid-GAP with INTERVAL=10 -> Req is delayed by exactly 5 cycles; Enable=0 during REQ does not drop Req.
REQ-040 Directed scenario, stuck grant: GntDnStr held high for 4 cycles -> SentCount increments by exactly 1; FSM leaves RELEASE only after Gnt=0.
REQ-041 Directed scenario, payload: LFSR_SEED=9'h1FF, 3 grants -> payloads 9'h1FF, then the next two x^9+x^5+1 states, checked against a reference model; ModuleID field constant.
REQ-042 Directed scenario, reset mid-REQ: reset=0 while Req=1 -> next edge Req=0, SentCount=0, PacketOut={1,0,ModuleID,9'h1FF}.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field layout, default bus width, injector
// state encodings and the payload LFSR step function.
package noc_pkg;

    localparam int PKT_WIDTH  = 26;

    localparam int VALID_BIT  = 25;
    localparam int PKTID_MSB  = 24;
    localparam int PKTID_LSB  = 15;
    localparam int SENDER_MSB = 14;
    localparam int SENDER_LSB = 9;
    localparam int DATA_MSB   = 8;
    localparam int DATA_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GAP     = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } inj_state_e;

    // Fibonacci x^9 + x^5 + 1: shift toward the MSB, feed back taps 9 and 5
    function automatic logic [8:0] lfsr9_next(input logic [8:0] q);
        return {q[7:0], q[8] ^ q[4]};
    endfunction

endpackage

// File: rtl/lfsr9.sv
// 9-bit payload generator; loads the seed in reset and steps only when told to.
module lfsr9
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [8:0] seed,
    output logic [8:0] q
);

    logic [8:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= seed;
        end else if (advance) begin
            r_q <= lfsr9_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/packet_injector.sv
// Processing-element traffic source: emits NUM_PACKETS packets to the router
// local port, spaced by INTERVAL idle cycles, with a req/grant handshake.
//
// state   | meaning
// IDLE    | waiting for Enable to start the first gap
// GAP     | gap counter running (holds while Enable=0 or router full at expiry)
// REQ     | ReqDnStr high, packet held stable until a grant is sampled
// RELEASE | grant taken, waiting for GntDnStr to drop
// DONE    | all packets granted; parked until reset
module packet_injector
    import noc_pkg::*;
#(
    parameter logic [5:0]  routerID    = 6'b000_000,
    parameter logic [5:0]  ModuleID    = 6'b000_000,
    parameter int          packetwidth = PKT_WIDTH,
    parameter logic [15:0] INTERVAL    = 16'd10,
    parameter logic [9:0]  NUM_PACKETS = 10'd100,
    parameter logic [8:0]  LFSR_SEED   = 9'h1FF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Enable,
    input  logic                   DnStrFull,
    input  logic                   GntDnStr,
    output logic                   ReqDnStr,
    output logic [packetwidth-1:0] PacketOut,
    output logic [9:0]             SentCount,
    output logic                   Done
);

    // routerID only tags the instance; this keeps it referenced at elaboration
    if ($bits(routerID) != 6) begin : g_router_id_width_unsupported
    end

    inj_state_e r_state;
    inj_state_e w_state_nxt;
    logic [15:0] r_gap_cnt;
    logic [15:0] w_gap_cnt_nxt;
    logic        r_req;
    logic        w_req_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [9:0]  r_sent_cnt;
    logic [9:0]  w_sent_cnt_nxt;
    logic [9:0]  r_pkt_id;
    logic [9:0]  w_pkt_id_nxt;
    logic        w_grant;
    logic [8:0]  w_lfsr_q;
    logic [packetwidth-1:0] w_packet;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gap_cnt  <= 16'd0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_sent_cnt <= 10'd0;
            r_pkt_id   <= 10'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_req      <= w_req_nxt;
            r_done     <= w_done_nxt;
            r_sent_cnt <= w_sent_cnt_nxt;
            r_pkt_id   <= w_pkt_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_req_nxt      = r_req;
        w_done_nxt     = r_done;
        w_sent_cnt_nxt = r_sent_cnt;
        w_pkt_id_nxt   = r_pkt_id;
        w_grant        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Enable) begin
                    w_gap_cnt_nxt = INTERVAL;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (Enable) begin
                    // terminal count: leave only when the router has room
                    if (r_gap_cnt <= 16'd1) begin
                        if (!DnStrFull) begin
                            w_req_nxt   = 1'b1;
                            w_state_nxt = ST_REQ;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 16'd1;
                    end
                end
            end
            ST_REQ: begin
                if (GntDnStr) begin
                    w_grant        = 1'b1;
                    w_req_nxt      = 1'b0;
                    w_sent_cnt_nxt = r_sent_cnt + 10'd1;
                    w_pkt_id_nxt   = r_pkt_id + 10'd1;
                    w_state_nxt    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!GntDnStr) begin
                    if (r_sent_cnt == NUM_PACKETS) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_gap_cnt_nxt = INTERVAL;
                        w_state_nxt   = ST_GAP;
                    end
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                w_req_nxt  = 1'b0;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    lfsr9 u_lfsr9 (
        .clk     (clk),
        .reset   (reset),
        .advance (w_grant),
        .seed    (LFSR_SEED),
        .q       (w_lfsr_q)
    );

    always_comb begin
        w_packet                        = '0;
        w_packet[VALID_BIT]             = 1'b1;
        w_packet[PKTID_MSB:PKTID_LSB]   = r_pkt_id;
        w_packet[SENDER_MSB:SENDER_LSB] = ModuleID;
        w_packet[DATA_MSB:DATA_LSB]     = w_lfsr_q;
    end

    assign ReqDnStr  = r_req;
    assign PacketOut = w_packet;
    assign SentCount = r_sent_cnt;
    assign Done      = r_done;

endmodule
